// File: rtl/aes256_round_ctrl_if.sv
// aes256_round_ctrl_if
//   Block I/O handshake bundle for the AES-256 round controller.
//   Signal names keep the controller's original port names so existing
//   integration code maps one-to-one.
//
//   in_valid_i   upstream -> ctrl   input block valid
//   in_ready_o   ctrl -> upstream   controller can accept a block
//   mode_i       upstream -> ctrl   0=encrypt, 1=decrypt (sampled on handshake)
//   data_i       upstream -> ctrl   128-bit input block, byte0 = [127:120]
//   out_valid_o  ctrl -> downstream result valid
//   out_ready_i  downstream -> ctrl result accepted
//   data_o       ctrl -> downstream 128-bit result block
//
//   master : the block source/sink side (drives inputs, consumes results)
//   slave  : the controller side
interface aes256_round_ctrl_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         mode_i;
    logic [127:0] data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] data_o;

    modport master (
        output in_valid_i,
        output mode_i,
        output data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  data_o
    );

    modport slave (
        input  in_valid_i,
        input  mode_i,
        input  data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output data_o
    );
endinterface

// File: rtl/aes256_round_ctrl.sv
// aes256_round_ctrl
//   Iterative AES-256 round sequencer. Accepts one 128-bit block per
//   valid/ready handshake, applies the initial AddRoundKey itself, then
//   drives the shared combinational round datapath for NR rounds (one per
//   clock) while holding the state register, and presents the result on a
//   valid/ready output. Round-key indices go to the expanded-key store,
//   which answers combinationally on rk_i in the same cycle.
//
//   Sequence: IDLE -> INIT (1 clk) -> ROUND (NR clks) -> DONE -> IDLE.
//
// Parameters
//   NR          number of rounds (14 for AES-256; other values unsupported)
//   KIDX_W      width of the round-key index (covers 0..NR)
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous abort: back to IDLE, in-flight block dropped
//   key_ready_i  expanded key valid in the key store (looked at in IDLE only)
//   blk          block I/O handshake bundle (slave side)
//   rk_idx_o     round-key index to the key store
//   rk_i         round key for rk_idx_o, same cycle
//   rnd_mode_o   latched mode to the round datapath
//   rnd_last_o   final round: datapath skips (Inv)MixColumns
//   rnd_state_o  current state register to the round datapath
//   rnd_state_i  round datapath result (AddRoundKey with rk_i included)
//   busy_o       controller is not in IDLE
module aes256_round_ctrl #(
    parameter int unsigned NR     = 14,
    parameter int unsigned KIDX_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                key_ready_i,
    aes256_round_ctrl_if.slave  blk,
    output logic [KIDX_W-1:0]   rk_idx_o,
    input  logic [127:0]        rk_i,
    output logic                rnd_mode_o,
    output logic                rnd_last_o,
    output logic [127:0]        rnd_state_o,
    input  logic [127:0]        rnd_state_i,
    output logic                busy_o
);

    localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        DONE
    } fsm_e;

    fsm_e               fsm_q;
    logic [127:0]       state_q;
    logic               mode_q;
    logic [KIDX_W-1:0]  rnd_cnt_q;
    logic [KIDX_W-1:0]  rk_idx_q;
    logic               last_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               accept;
    logic [KIDX_W-1:0]  cnt_inc;

    // Key index used by the round that executes with round count cnt.
    // Decryption walks the schedule from the top (NR) down to 0.
    function automatic logic [KIDX_W-1:0] key_index(input logic               dec,
                                                   input logic [KIDX_W-1:0]  cnt);
        return dec ? (NR_K - cnt) : cnt;
    endfunction

    assign accept  = (fsm_q == IDLE) && key_ready_i && blk.in_valid_i;
    assign cnt_inc = rnd_cnt_q + ONE_K;

    // rk_idx_o and rnd_last_o are registered: each transition loads the
    // values the *next* cycle needs, so the key store sees a glitch-free
    // index straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            mode_q      <= 1'b0;
            rnd_cnt_q   <= '0;
            rk_idx_q    <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear_i) begin
            // Abort leaves state_q/mode_q as they are; only control is reset.
            fsm_q       <= IDLE;
            rnd_cnt_q   <= '0;
            rk_idx_q    <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= blk.data_i;
                        mode_q   <= blk.mode_i;
                        rk_idx_q <= key_index(blk.mode_i, '0);
                        busy_q   <= 1'b1;
                        fsm_q    <= INIT;
                    end
                end

                INIT: begin
                    // Initial AddRoundKey is done here, not in the datapath.
                    state_q   <= state_q ^ rk_i;
                    rnd_cnt_q <= ONE_K;
                    rk_idx_q  <= key_index(mode_q, ONE_K);
                    last_q    <= (ONE_K == NR_K);
                    fsm_q     <= ROUND;
                end

                ROUND: begin
                    state_q <= rnd_state_i;
                    if (rnd_cnt_q == NR_K) begin
                        // Counter parks at 0 rather than stepping past NR.
                        rnd_cnt_q   <= '0;
                        rk_idx_q    <= '0;
                        last_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        rnd_cnt_q <= cnt_inc;
                        rk_idx_q  <= key_index(mode_q, cnt_inc);
                        last_q    <= (cnt_inc == NR_K);
                    end
                end

                DONE: begin
                    if (blk.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end

                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign blk.in_ready_o  = (fsm_q == IDLE) && key_ready_i;
    assign blk.out_valid_o = out_valid_q;
    assign blk.data_o      = state_q;

    assign rk_idx_o    = rk_idx_q;
    assign rnd_mode_o  = mode_q;
    assign rnd_last_o  = last_q;
    assign rnd_state_o = state_q;
    assign busy_o      = busy_q;

    // Output handshake must hold until accepted (clear/reset excepted).
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_q && !blk.out_ready_i && !clear_i) |=> out_valid_q);

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rnd_cnt_q <= NR_K);

    a_ready_idle_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
        blk.in_ready_o |-> (fsm_q == IDLE));

endmodule

// File: tb/tb_aes256_round_ctrl.sv
`timescale 1ns/1ps
module tb_aes256_round_ctrl;

    localparam int unsigned NR     = 14;
    localparam int unsigned KIDX_W = 4;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef logic [0:NR][127:0] rkeys_t;
    typedef struct {
        logic [127:0] data;
        int unsigned  hs_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              key_ready;
    logic [KIDX_W-1:0] rk_idx;
    logic [127:0]      rk;
    logic              rnd_mode;
    logic              rnd_last;
    logic [127:0]      rnd_state_o;
    logic [127:0]      rnd_state_i;
    logic              busy;

    aes256_round_ctrl_if blk_if();

    aes256_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .key_ready_i (key_ready),
        .blk         (blk_if),
        .rk_idx_o    (rk_idx),
        .rk_i        (rk),
        .rnd_mode_o  (rnd_mode),
        .rnd_last_o  (rnd_last),
        .rnd_state_o (rnd_state_o),
        .rnd_state_i (rnd_state_i),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        exp_q[$];
    int unsigned ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    // ---------------- AES arithmetic (reference + datapath stand-in) ----------
    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        int src;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) begin
                src = inv ? ((c - rw + 4) % 4) : ((c + rw) % 4);
                r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*src) -: 8];
            end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   co [4];
        logic [7:0]   acc;
        co = inv ? '{8'd14, 8'd11, 8'd13, 8'd9} : '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int rw = 0; rw < 4; rw++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[(rw+k)%4], co[k]);
                r[127-8*(4*c+rw) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic rkeys_t expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        rkeys_t      ks;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r <= 14; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Whole-block reference cipher (FIPS-197 Cipher / InvCipher).
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] din,
                                             input bit dec);
        rkeys_t       ks = expand(key);
        logic [127:0] s;
        if (!dec) begin
            s = din ^ ks[0];
            for (int r = 1; r <= 14; r++) begin
                s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
                if (r != 14) s = mix_columns(s, 1'b0);
                s = s ^ ks[r];
            end
        end else begin
            s = din ^ ks[14];
            for (int r = 13; r >= 0; r--) begin
                s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
                s = s ^ ks[r];
                if (r != 0) s = mix_columns(s, 1'b1);
            end
        end
        return s;
    endfunction

    // Stand-in for the external round datapath and key store.
    function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic dec, input logic last);
        logic [127:0] t;
        if (!dec) begin
            t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (!last) t = mix_columns(t, 1'b0);
            return t ^ k;
        end
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!last) t = mix_columns(t, 1'b1);
        return t;
    endfunction

    rkeys_t key_store;
    assign rk          = key_store[rk_idx];
    assign rnd_state_i = dp_round(rnd_state_o, rk, rnd_mode, rnd_last);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired without the required event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        blk_if.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       blk_if.out_ready_i = 1'b0;
                1:       blk_if.out_ready_i = 1'b1;
                default: blk_if.out_ready_i = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    // Latency: out_valid must rise 15 edges after the handshake edge, i.e. it is
    // seen in the 16th clock counting the handshake clock as the first.
    initial begin : monitor
        exp_t        e;
        bit          prev_valid = 1'b0;
        int unsigned rise_cyc   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (blk_if.out_valid_o && !prev_valid) rise_cyc = cyc;
                prev_valid = blk_if.out_valid_o;
                if (blk_if.out_valid_o && blk_if.out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: data_o %h with no block outstanding",
                                 blk_if.data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_o", blk_if.data_o, e.data);
                        chk("latency", rise_cyc - e.hs_cyc, 15);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d, input logic m, input logic [127:0] exp,
                        output int unsigned hs);
        bit got = 1'b0;
        hs = 0;
        blk_if.in_valid_i = 1'b1;
        blk_if.data_i     = d;
        blk_if.mode_i     = m;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (blk_if.in_ready_o) got = 1'b1;
        end
        if (got) begin
            step();
            hs = cyc;
            exp_q.push_back('{data: exp, hs_cyc: hs});
        end else begin
            fail_bound("accept_timeout");
        end
        blk_if.in_valid_i = 1'b0;
        blk_if.data_i     = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (exp_q.size() == 0 && !busy) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) fail_bound("drain_timeout");
        step();
    endtask

    // Called in the INIT cycle: follows rk_idx/rnd_last through INIT and ROUND.
    task automatic trace(input logic m);
        for (int k = 0; k <= int'(NR); k++) begin
            @(negedge clk);
            chk($sformatf("rk_idx_m%0d_k%0d", m, k), 32'(rk_idx),
                m ? ((k == 0) ? NR : NR - k) : k);
            chk($sformatf("rnd_last_m%0d_k%0d", m, k), 32'(rnd_last), (k == int'(NR)) ? 1 : 0);
            chk("rnd_mode", 32'(rnd_mode), 32'(m));
            chk("busy_running", 32'(busy), 1);
        end
        @(negedge clk);
        chk("rk_idx_done", 32'(rk_idx), 0);
        chk("rnd_last_done", 32'(rnd_last), 0);
        chk("out_valid_done", 32'(blk_if.out_valid_o), 1);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main stimulus ----------------
    initial begin : stim
        int unsigned  hs;
        int unsigned  prev_hs;
        bit           got;
        bit           seen;
        logic [127:0] d;
        logic [127:0] held;
        logic [255:0] key;
        logic         m;

        rst_n             = 1'b0;
        clear             = 1'b0;
        key_ready         = 1'b0;
        blk_if.in_valid_i = 1'b0;
        blk_if.mode_i     = 1'b0;
        blk_if.data_i     = '0;
        key_store         = '0;
        build_sbox();

        repeat (3) step();
        chk("rst_out_valid", 32'(blk_if.out_valid_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(blk_if.in_ready_o), 0);
        chk("rst_rnd_last", 32'(rnd_last), 0);
        chk("rst_rk_idx", 32'(rk_idx), 0);
        check("rst_data_o", blk_if.data_o, '0);

        rst_n = 1'b1;
        step();
        key_store = expand(FIPS_KEY);
        key_ready = 1'b1;
        step();
        chk("idle_in_ready", 32'(blk_if.in_ready_o), 1);

        // FIPS-197 C.3 encrypt and decrypt, with key-index trace.
        ready_mode = 1;
        send(FIPS_PT, 1'b0, FIPS_CT, hs);
        trace(1'b0);
        wait_idle();
        send(FIPS_CT, 1'b1, FIPS_PT, hs);
        trace(1'b1);
        wait_idle();

        // Backpressure: result held 20 cycles, then released.
        ready_mode = 0;
        step();
        d = rand128();
        send(d, 1'b0, aes_ref(FIPS_KEY, d, 1'b0), hs);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (blk_if.out_valid_o) got = 1'b1;
        end
        if (!got) fail_bound("bp_valid_timeout");
        held = blk_if.data_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(blk_if.out_valid_o), 1);
            check("bp_data_o", blk_if.data_o, held);
            chk("bp_in_ready", 32'(blk_if.in_ready_o), 0);
        end
        ready_mode = 1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (blk_if.out_ready_i) got = 1'b1;
        end
        if (!got) fail_bound("bp_release_timeout");
        chk("bp_valid_at_release", 32'(blk_if.out_valid_o), 1);
        @(negedge clk);
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_idle_in_ready", 32'(blk_if.in_ready_o), 1);
        chk("bp_valid_dropped", 32'(blk_if.out_valid_o), 0);
        wait_idle();

        // Key not ready: a pending block must not be taken.
        key_ready         = 1'b0;
        d                 = rand128();
        blk_if.in_valid_i = 1'b1;
        blk_if.data_i     = d;
        blk_if.mode_i     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("nokey_in_ready", 32'(blk_if.in_ready_o), 0);
            chk("nokey_busy", 32'(busy), 0);
        end
        step();
        key_ready = 1'b1;
        send(d, 1'b1, aes_ref(FIPS_KEY, d, 1'b1), hs);
        wait_idle();

        // Abort in ROUND cycle 7.
        d = rand128();
        send(d, 1'b0, aes_ref(FIPS_KEY, d, 1'b0), hs);
        repeat (7) @(posedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        chk("clr_round7_idx", 32'(rk_idx), 7);
        step();
        clear = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_out_valid", 32'(blk_if.out_valid_o), 0);
        chk("clr_rk_idx", 32'(rk_idx), 0);
        chk("clr_in_ready", 32'(blk_if.in_ready_o), 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (blk_if.out_valid_o) seen = 1'b1;
        end
        chk("clr_no_valid", 32'(seen), 0);
        step();
        d = rand128();
        send(d, 1'b1, aes_ref(FIPS_KEY, d, 1'b1), hs);
        wait_idle();

        // Asynchronous reset while a result waits in DONE.
        ready_mode = 0;
        step();
        d = rand128();
        send(d, 1'b1, aes_ref(FIPS_KEY, d, 1'b1), hs);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (blk_if.out_valid_o) got = 1'b1;
        end
        if (!got) fail_bound("rst_valid_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(blk_if.out_valid_o), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rnd_last", 32'(rnd_last), 0);
        chk("arst_rk_idx", 32'(rk_idx), 0);
        chk("arst_rnd_mode", 32'(rnd_mode), 0);
        chk("arst_in_ready", 32'(blk_if.in_ready_o), 1);
        check("arst_data_o", blk_if.data_o, '0);
        exp_q.delete();
        ready_mode = 1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Back-to-back blocks with continuous ready: 17-clock spacing.
        prev_hs = 0;
        for (int n = 0; n < 3; n++) begin
            d = rand128();
            m = n[0];
            send(d, m, aes_ref(FIPS_KEY, d, m), hs);
            if (n > 0) chk("b2b_spacing", hs - prev_hs, 17);
            prev_hs = hs;
        end
        wait_idle();

        // Randomised traffic under random backpressure, fresh key per batch.
        ready_mode = 2;
        for (int b = 0; b < 3; b++) begin
            wait_idle();
            key       = {rand128(), rand128()};
            key_store = expand(key);
            for (int n = 0; n < 8; n++) begin
                repeat ($urandom_range(0, 3)) step();
                d = rand128();
                m = 1'($urandom_range(0, 1));
                send(d, m, aes_ref(key, d, m), hs);
            end
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
